// File: rtl/pe_weight_loader_if.sv
// Bundle of the control, AXI-read-side and weight-bus signals of pe_weight_loader.
//
// Handshake semantics: START is a single-cycle request that is accepted only
// while BUSY is low; any START seen while BUSY is high is dropped. On the read
// side M_AXI_RVALID_RREADY is the already-qualified beat strobe (RVALID && RREADY),
// so every cycle it is high carries exactly one beat on M_AXI_RDATA. TXN_DONE
// and AXI_ERROR are single-cycle status strobes from the AXI master FSM.
interface pe_weight_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ROW_WIDTH  = 40
);
    logic                  START;
    logic [DATA_WIDTH-1:0] WEIGHT_BASE_ADDR;
    logic [DATA_WIDTH-1:0] M_TARGET_SLAVE_BASE_AR_ADDR;
    logic                  INIT_AXI_RD_TXN;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic                  M_AXI_RVALID_RREADY;
    logic                  TXN_DONE;
    logic                  AXI_ERROR;
    logic [ROW_WIDTH-1:0]  WEIGHTS_OUT_0;
    logic [ROW_WIDTH-1:0]  WEIGHTS_OUT_1;
    logic [ROW_WIDTH-1:0]  WEIGHTS_OUT_2;
    logic [ROW_WIDTH-1:0]  WEIGHTS_OUT_3;
    logic [ROW_WIDTH-1:0]  WEIGHTS_OUT_4;
    logic                  WEIGHTS_VALID;
    logic                  BUSY;
    logic                  DONE;
    logic                  LOAD_ERROR;
    logic [2:0]            state_dbg;

    // The loader itself.
    modport slave (
        input  START, WEIGHT_BASE_ADDR, M_AXI_RDATA, M_AXI_RVALID_RREADY,
               TXN_DONE, AXI_ERROR,
        output M_TARGET_SLAVE_BASE_AR_ADDR, INIT_AXI_RD_TXN,
               WEIGHTS_OUT_0, WEIGHTS_OUT_1, WEIGHTS_OUT_2, WEIGHTS_OUT_3, WEIGHTS_OUT_4,
               WEIGHTS_VALID, BUSY, DONE, LOAD_ERROR, state_dbg
    );

    // Whoever drives the loader (register block plus AXI master FSM).
    modport master (
        output START, WEIGHT_BASE_ADDR, M_AXI_RDATA, M_AXI_RVALID_RREADY,
               TXN_DONE, AXI_ERROR,
        input  M_TARGET_SLAVE_BASE_AR_ADDR, INIT_AXI_RD_TXN,
               WEIGHTS_OUT_0, WEIGHTS_OUT_1, WEIGHTS_OUT_2, WEIGHTS_OUT_3, WEIGHTS_OUT_4,
               WEIGHTS_VALID, BUSY, DONE, LOAD_ERROR, state_dbg
    );
endinterface

// File: rtl/pe_weight_loader.sv
// Fetches one PE weight tile with a single AXI read burst, unpacks the beats
// into shadow byte registers and commits the whole tile to the PE weight bus
// in one cycle, so the array keeps stable weights while the next tile loads.
module pe_weight_loader #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_BURST_LEN  = 16,
    parameter int PE_ROWS              = 5,
    parameter int PE_COLS              = 5,
    parameter int BYTE_LEN             = 8
) (
    input  logic            CLK,
    input  logic            RESETN,
    pe_weight_loader_if.slave bus
);
    localparam int NUM_BYTES  = PE_ROWS * PE_COLS;
    localparam int BEAT_BYTES = C_M00_AXI_DATA_WIDTH / BYTE_LEN;
    localparam int NUM_WORDS  = (NUM_BYTES * BYTE_LEN + C_M00_AXI_DATA_WIDTH - 1) / C_M00_AXI_DATA_WIDTH;
    // A burst can never deliver more beats than its length, so the counter stops at the smaller.
    localparam int CNT_LIMIT  = (C_M00_AXI_BURST_LEN < NUM_WORDS) ? C_M00_AXI_BURST_LEN : NUM_WORDS;
    localparam int CNT_W      = $clog2(NUM_WORDS + 1);
    localparam int ROW_W      = PE_COLS * BYTE_LEN;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RECV = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                         state;
    logic [CNT_W-1:0]               beat_cnt;
    logic [CNT_W-1:0]               beat_cnt_next;
    logic [BYTE_LEN-1:0]            shadow_q    [NUM_BYTES];
    logic [BYTE_LEN-1:0]            shadow_next [NUM_BYTES];
    logic [ROW_W-1:0]               rows_q      [PE_ROWS];
    logic                           beat_fire;
    logic [C_M00_AXI_DATA_WIDTH-1:0] addr_q;
    logic                           init_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           valid_q;
    logic                           err_q;

    // Beat acceptance and the shadow image including this cycle's beat, so a
    // beat arriving together with TXN_DONE is counted and committed.
    always_comb begin
        beat_fire     = (state == S_RECV) && bus.M_AXI_RVALID_RREADY
                        && (beat_cnt < CNT_W'(CNT_LIMIT));
        beat_cnt_next = beat_cnt;
        if (beat_fire) begin
            beat_cnt_next = beat_cnt + 1'b1;
        end
        shadow_next = shadow_q;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (beat_fire && ((k / BEAT_BYTES) == int'(beat_cnt))) begin
                shadow_next[k] = bus.M_AXI_RDATA[(k % BEAT_BYTES) * BYTE_LEN +: BYTE_LEN];
            end
        end
    end

    // Load sequencer: state, counters, shadow/committed weights and all registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            addr_q   <= '0;
            init_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            for (int k = 0; k < NUM_BYTES; k++) begin
                shadow_q[k] <= '0;
            end
            for (int r = 0; r < PE_ROWS; r++) begin
                rows_q[r] <= '0;
            end
        end else begin
            shadow_q <= shadow_next;
            beat_cnt <= beat_cnt_next;
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        state    <= S_REQ;
                        busy_q   <= 1'b1;
                        init_q   <= 1'b1;
                        addr_q   <= bus.WEIGHT_BASE_ADDR;
                        err_q    <= 1'b0;
                        valid_q  <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                S_REQ: begin
                    init_q <= 1'b0;
                    if (bus.AXI_ERROR) begin
                        state <= S_ERR;
                        err_q <= 1'b1;
                    end else begin
                        state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (bus.AXI_ERROR) begin
                        state <= S_ERR;
                        err_q <= 1'b1;
                    end else if (bus.TXN_DONE) begin
                        if (beat_cnt_next >= CNT_W'(NUM_WORDS)) begin
                            state   <= S_DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                            for (int r = 0; r < PE_ROWS; r++) begin
                                for (int c = 0; c < PE_COLS; c++) begin
                                    rows_q[r][c * BYTE_LEN +: BYTE_LEN] <= shadow_next[r * PE_COLS + c];
                                end
                            end
                        end else begin
                            state <= S_ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                S_ERR: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    init_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.M_TARGET_SLAVE_BASE_AR_ADDR = addr_q;
    assign bus.INIT_AXI_RD_TXN             = init_q;
    assign bus.WEIGHTS_OUT_0               = rows_q[0];
    assign bus.WEIGHTS_OUT_1               = rows_q[1];
    assign bus.WEIGHTS_OUT_2               = rows_q[2];
    assign bus.WEIGHTS_OUT_3               = rows_q[3];
    assign bus.WEIGHTS_OUT_4               = rows_q[4];
    assign bus.WEIGHTS_VALID               = valid_q;
    assign bus.BUSY                        = busy_q;
    assign bus.DONE                        = done_q;
    assign bus.LOAD_ERROR                  = err_q;
    assign bus.state_dbg                   = state;
endmodule
